// File: rtl/key_expan_pkg.sv
// Shared AES-128 key-schedule constants: sizes, Rcon table, forward S-box and FSM states.
package key_expan_pkg;

    localparam int KEY_WIDTH  = 128;
    localparam int NUM_ROUNDS = 10;
    localparam int NUM_KEYS   = NUM_ROUNDS + 1;
    localparam int EXP_WIDTH  = NUM_KEYS * KEY_WIDTH;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } state_e;

    // Round 1 constant sits in the top byte.
    localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

    // Entry 0x00 sits in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        if (rnd == 4'd0 || rnd > 4'(NUM_ROUNDS))
            return 8'h00;
        return RCON_TBL[(NUM_ROUNDS - int'(rnd)) * 8 +: 8];
    endfunction

endpackage

// File: rtl/key_expan_if.sv
// Start strobe, cipher key and expanded-key bus between the key-schedule block and its user.
interface key_expan_if
    import key_expan_pkg::*;
#(
    parameter int KW  = KEY_WIDTH,
    parameter int EKW = EXP_WIDTH
);
    logic           en;
    logic [KW-1:0]  initial_key;
    logic [EKW-1:0] key_reg;

    modport master (output en, output initial_key, input key_reg);
    modport slave  (input en, input initial_key, output key_reg);
endinterface

// File: rtl/key_expan_aes_key_round.sv
// One AES-128 key-schedule step: next round key from the previous one and its Rcon byte.
module aes_key_round
    import key_expan_pkg::*;
(
    input  logic [KEY_WIDTH-1:0] prev_key_i,
    input  logic [7:0]           rcon_i,
    output logic [KEY_WIDTH-1:0] next_key_o
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, temp_w;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key_i;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign sub_w[b*8 +: 8] = sbox(rot_w[b*8 +: 8]);
    end

    assign temp_w = sub_w ^ {rcon_i, 24'h000000};
    assign n0 = w0 ^ temp_w;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key_o = {n0, n1, n2, n3};
endmodule

// File: rtl/key_expan.sv
// Iterative AES-128 key expansion: one round key per cycle into 11 registered slots.
module key_expan
    import key_expan_pkg::*;
#(
    parameter int KEY_WIDTH_P        = KEY_WIDTH,
    parameter int EXPANDED_KEY_WIDTH = EXP_WIDTH
) (
    input  logic       clk,
    input  logic       reset_n,
    key_expan_if.slave bus
);
    localparam int NK = EXPANDED_KEY_WIDTH / KEY_WIDTH_P;

    state_e                              state_q, state_d;
    logic [3:0]                          rnd_q, rnd_d;
    logic [NK-1:0][KEY_WIDTH_P-1:0]      key_q, key_d;
    logic [KEY_WIDTH_P-1:0]              prev_key, next_key;
    logic [3:0]                          prev_idx;

    assign prev_idx = rnd_q - 4'd1;
    assign prev_key = key_q[prev_idx];

    aes_key_round u_round (
        .prev_key_i (prev_key),
        .rcon_i     (rcon(rnd_q)),
        .next_key_o (next_key)
    );

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        // A start strobe wins in either state, restarting from the new key.
        if (bus.en) begin
            key_d    = '0;
            key_d[0] = bus.initial_key;
            rnd_d    = 4'd1;
            state_d  = ST_EXPAND;
        end else if (state_q == ST_EXPAND) begin
            key_d[rnd_q] = next_key;
            if (rnd_q == 4'(NUM_ROUNDS)) begin
                rnd_d   = 4'd1;
                state_d = ST_IDLE;
            end else begin
                rnd_d = rnd_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= ST_IDLE;
            rnd_q   <= 4'd1;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
        end
    end

    assign bus.key_reg = key_q;
endmodule

// File: tb/tb_key_expan.sv
// Directed bench for key_expan with a queue of expected round keys checked as each slot fills.
module tb_key_expan;
    import key_expan_pkg::*;

    typedef struct {
        string        tag;
        int           slot;
        logic [127:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    key_expan_if bus ();

    key_expan dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    function automatic logic [127:0] slot(input int i);
        return bus.key_reg[i*128 +: 128];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 11; i++)
            chk($sformatf("%s_slot%0d", tag, i), slot(i), 128'h0);
    endtask

    task automatic push(input string tag, input int s, input logic [127:0] v);
        exp_t e;
        e.tag = tag; e.slot = s; e.val = v;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; the following posedge is edge E.
    task automatic pulse(input logic [127:0] key);
        bus.en          = 1'b1;
        bus.initial_key = key;
        @(negedge clk);
        bus.en          = 1'b0;
    endtask

    // Compare round keys from step `first` through `last`, one negedge per step after the first.
    task automatic run(input string tag, input int first, input int last);
        for (int r = first; r <= last; r++) begin
            if (r != first) @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].slot == r) begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.tag, slot(e.slot), e.val);
            end
            if (r == 0) begin
                for (int i = 1; i < 11; i++)
                    chk($sformatf("%s_clr%0d", tag, i), slot(i), 128'h0);
            end else if (r < 10) begin
                chk($sformatf("%s_fill%0d", tag, r + 1), slot(r + 1), 128'h0);
            end
        end
    endtask

    initial begin
        bus.en          = 1'b0;
        bus.initial_key = '0;
        reset_n         = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("rst");
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("idle");

        // Full FIPS-197 schedule, then hold in IDLE.
        for (int i = 0; i < 11; i++) push($sformatf("fips_r%0d", i), i, FIPS_RK[i]);
        pulse(FIPS_KEY);
        run("fips", 0, 10);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 11; i++) chk($sformatf("hold_r%0d", i), slot(i), FIPS_RK[i]);

        // All-zero key.
        push("zero_r0", 0, 128'h0);
        push("zero_r1", 1, ZERO_R1);
        push("zero_r10", 10, ZERO_R10);
        pulse(128'h0);
        run("zero", 0, 10);

        // Restart with a new key while round 5 is next.
        for (int i = 0; i < 5; i++) push($sformatf("pre_r%0d", i), i, FIPS_RK[i]);
        pulse(FIPS_KEY);
        run("pre", 0, 4);
        push("rst_r0", 0, 128'h0);
        push("rst_r1", 1, ZERO_R1);
        push("rst_r10", 10, ZERO_R10);
        pulse(128'h0);
        run("restart", 0, 10);

        // Reset during round 4 aborts and zeroes everything.
        for (int i = 0; i < 4; i++) push($sformatf("abort_r%0d", i), i, FIPS_RK[i]);
        pulse(FIPS_KEY);
        run("abort", 0, 3);
        reset_n = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        reset_n = 1'b0;
        repeat (12) @(negedge clk);
        chk_all_zero("postrst");

        n_chk++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_empty observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/key_expan.md
KEY_EXPAN -- requirements
Module: key_expan

Interface
REQ-001 Parameter KEY_WIDTH, default 128, width of the cipher key and of each round key.
REQ-002 Parameter EXPANDED_KEY_WIDTH, default 1408 (11 x 128), width of the packed expanded-key output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset is synchronous and active-high (asserted when 1), sampled on rising clk edge.
REQ-005 en  input  1  start strobe, one-cycle pulse; samples initial_key and starts an expansion.
REQ-006 initial_key  input  128  AES-128 cipher key, bit 127 = first key byte MSB.
REQ-007 key_reg  output  1408  registered expanded key; round i key at bits [(i+1)*128-1 : i*128], i = 0..10.

Function
REQ-008 Expansion SHALL follow FIPS-197 AES-128: w[i] = w[i-4] XOR temp, temp = SubWord(RotWord(w[i-1])) XOR Rcon[i/4] when i mod 4 = 0, else w[i-1].
REQ-009 Within each 128-bit round key, word w[4r] SHALL occupy bits [127:96] and w[4r+3] bits [31:0].
REQ-010 Rcon SHALL be 01,02,04,08,10,20,40,80,1b,36 (in the MS byte) for rounds 1..10.
REQ-011 States: IDLE and EXPAND; a 4-bit round counter holds the next round to compute (1..10).
REQ-012 IDLE with en=1: round-0 slot <= initial_key, slots 1..10 <= 0, counter <= 1, go EXPAND (edge E).
REQ-013 EXPAND: each cycle compute one round key from the previous slot, write slot[counter], counter increments.
REQ-014 Round r key SHALL be valid r cycles after edge E; round 10 valid at edge E+10, then return to IDLE.
REQ-015 en=1 during EXPAND SHALL restart: behave exactly as REQ-012 with the new initial_key.
REQ-016 In IDLE with en=0, key_reg SHALL hold its value indefinitely.
REQ-017 SubWord SHALL use the standard AES forward S-box (combinational, 4 instances).
REQ-018 All arithmetic is GF(2) XOR; no carries; counter never exceeds 10.

Reset
REQ-019 reset_n=1 at a rising edge SHALL clear key_reg to 0, counter to 1, state to IDLE.
REQ-020 Reset SHALL take priority over en and over an expansion in progress (abort, outputs zeroed).
REQ-021 After reset deasserts, no output change until en is sampled high.

Structure
REQ-022 A shared package SHALL hold KEY_WIDTH, round count (10), the Rcon table, the S-box function and the state enum.
REQ-023 One sub-module aes_key_round SHALL compute next round key from (previous round key, Rcon byte), purely combinational.
REQ-024 key_expan SHALL contain only the FSM, counter, 11 round-key registers and one aes_key_round instance.

Verification
REQ-025 Reset 2 cycles, then idle -> key_reg = 0 throughout.
REQ-026 en pulse with 2b7e151628aed2a6abf7158809cf4f3c, wait 11 cycles -> round0 = 2b7e151628aed2a6abf7158809cf4f3c, round1 = a0fafe1788542cb123a339392a6c7605, round2 = f2c295f27a96b9435935807a7359f67f, round10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-027 Same key, sample after edge E+1 -> only slots 0 and 1 nonzero; check slots fill one per cycle.
REQ-028 All-zero key -> round1 = 62636363626363636263636362636363, round10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 Re-issue en with new key at round 5 -> slots 1..10 cleared, expansion restarts, final keys match new key only.
REQ-030 Assert reset_n mid-expansion (round 4) -> key_reg = 0 next edge, no further updates until en.
